data_mem: RTL
=============

// Module: data_mem
// PURPOSE
//   Responder for the core's data-memory port: word-addressed RAM with byte-mask writes and 1-cycle registered read.
//   Also hosts an MMIO page with a GPIO register, a TX byte FIFO drained over a valid/ready stream, and a status register.
//   Sits between core (o_mem_*) and board I/O. The core holds a load's address for 2 cycles (load stall), so the read latency is exactly 1.
// PARAMETERS
//   DEPTH      1024            RAM size in 32-bit words; power of 2; RAM index = i_mem_addr[$clog2(DEPTH)-1:0]
//   MMIO_BASE  30'h0400_0000   word address of MMIO page (byte 0x1000_0000); page hit when i_mem_addr[29:4] == MMIO_BASE[29:4]
//   FIFO_DEPTH 8               TX FIFO entries; power of 2, 2..128
//   GPIO_W     8               width of o_gpio
// PORTS
//   clk         in   1       clock, all state on posedge
//   rst_n       in   1       asynchronous active-low reset
//   i_mem_addr  in   30      word address from core
//   i_mem_data  in   32      write data, already lane-aligned by core LSU
//   i_mem_we    in   1       write strobe, one cycle per store
//   i_mem_mask  in   4       byte-lane enables for writes; ignored on reads
//   o_mem_data  out  32      read data for the address presented on the previous cycle
//   o_gpio      out  GPIO_W  GPIO output register
//   o_tx_data   out  8       FIFO head byte
//   o_tx_valid  out  1       FIFO not empty
//   i_tx_ready  in   1       downstream accepts; pop when o_tx_valid && i_tx_ready
// BEHAVIOUR
//   Reset values: o_mem_data=0, o_gpio=0, FIFO empty (o_tx_valid=0, o_tx_data=0), overflow=0, cycle=0. RAM contents are not reset.
//   Read: every cycle, o_mem_data <= word at i_mem_addr (RAM or MMIO), regardless of i_mem_we. There is no read enable, so reads have no side effects.
//   RAM write: if i_mem_we and not an MMIO hit, write each byte lane i where i_mem_mask[i]=1.
//     Addresses outside RAM alias modulo DEPTH.
//   Same-address read during write: read-first; o_mem_data returns the old word.
//   MMIO map (word offset = i_mem_addr[3:0]):
//     0x0 GPIO     RW   byte-masked write to bits [GPIO_W-1:0]; read zero-extended
//     0x1 TX_DATA  WO   write with mask[0]=1 pushes i_mem_data[7:0]; reads 0
//     0x2 TX_STAT  R/W1C  [7:0] count, [8] empty, [9] full, [10] overflow (sticky)
//                  writing 1 to bit 10 with mask[1]=1 clears overflow; other bits are read-only
//     0x3 CYCLE    RO   see CONFIGURATION
//     0x4..0xF     reads 0, writes ignored
//   FIFO: circular buffer with rd/wr pointers and a count of $clog2(FIFO_DEPTH)+1 bits; pointers wrap at FIFO_DEPTH.
//     Push accepted if !full, or if full and a pop occurs the same cycle.
//     Rejected push: data dropped, overflow set; takes effect the cycle after the write.
//     Simultaneous push+pop: count unchanged, both pointers advance.
//     Pop on empty is impossible because o_tx_valid=0.
//     o_tx_data = entry at rd pointer; it is 0 when empty (masked) and must stay stable while o_tx_valid && !i_tx_ready.
//   Overflow set and W1C clear in the same cycle: set wins.
//   Async reset mid-operation: FIFO flushed, status cleared immediately; downstream sees o_tx_valid drop asynchronously.
// CONFIGURATION
//   DATA_MEM_CYCLE_EN defined: 32-bit free-running cycle counter.
//     Increments every clk, wraps 0xFFFF_FFFF -> 0, cleared by reset.
//     Read at MMIO 0x3 returns the value sampled at the read edge.
//   Not defined: no counter logic; MMIO 0x3 reads 0.
// TESTING
//   Write 0xDEADBEEF to word 5, mask 4'b1111; then mask 4'b0010 data 0x0000_1200; read word 5 -> 0xDEAD12EF one cycle later.
//   Write word 5 and present the same address in that cycle -> old data; next cycle -> new data.
//   Hold i_tx_ready=0; push 0x41..0x48 (8) -> STAT=0x208 (full, count 8); 9th push -> overflow=1, FIFO unchanged.
//   Then set i_tx_ready=1 -> bytes 0x41..0x48 in order, one per cycle; then STAT=0x500 (empty, overflow set).
//   Write 0x400 to STAT with mask 4'b0010 -> STAT=0x100.
//   Full FIFO with i_tx_ready=1 and push in the same cycle -> accepted, count stays 8, no overflow.
//   Assert rst_n=0 mid-drain -> o_tx_valid=0 and o_gpio=0 without waiting for a clock edge.
//   With DATA_MEM_CYCLE_EN: two reads of 0x3, 10 cycles apart, differ by 10. Without it: reads 0.

Source files
------------

// File: rtl/data_mem.sv
// data_mem: data-memory responder for the core's load/store port.
//   - Word-addressed RAM with byte-lane write enables and a 1-cycle registered
//     read (read-first on same-address read/write).
//   - One MMIO page: GPIO register, TX byte FIFO drained over valid/ready, and
//     a FIFO status register with a sticky, write-1-to-clear overflow flag.
//   - Optional free-running cycle counter at MMIO offset 0x3, enabled by
//     defining DATA_MEM_CYCLE_EN. Without it, that offset reads 0.
module data_mem #(
  parameter int          DEPTH      = 1024,
  parameter logic [29:0] MMIO_BASE  = 30'h0400_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          GPIO_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [29:0]       i_mem_addr,
  input  logic [31:0]       i_mem_data,
  input  logic              i_mem_we,
  input  logic [3:0]        i_mem_mask,
  output logic [31:0]       o_mem_data,
  output logic [GPIO_W-1:0] o_gpio,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0] OFF_GPIO = 4'h0;
  localparam logic [3:0] OFF_TXD  = 4'h1;
  localparam logic [3:0] OFF_STAT = 4'h2;
  localparam logic [3:0] OFF_CYC  = 4'h3;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          mmio_hit;
  logic [3:0]    mmio_off;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic          gpio_we;
  logic          push_req;
  logic          ovf_clr;

  assign mmio_hit = (i_mem_addr[29:4] == MMIO_BASE[29:4]);
  assign mmio_off = i_mem_addr[3:0];
  // Upper address bits are simply dropped, so out-of-range addresses alias.
  assign ram_idx  = i_mem_addr[AW-1:0];
  assign ram_we   = i_mem_we && !mmio_hit;
  assign gpio_we  = i_mem_we && mmio_hit && (mmio_off == OFF_GPIO);
  assign push_req = i_mem_we && mmio_hit && (mmio_off == OFF_TXD) && i_mem_mask[0];
  assign ovf_clr  = i_mem_we && mmio_hit && (mmio_off == OFF_STAT) &&
                    i_mem_mask[1] && i_mem_data[10];

  // ---------------------------------------------------------------------------
  // RAM: one byte-wide array per lane so each lane maps to a plain
  // single-port block RAM with its own write enable.
  // ---------------------------------------------------------------------------
  logic [31:0] ram_rd;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rd_reg;

      // Lane write plus registered read; non-blocking read returns the old word.
      always_ff @(posedge clk) begin
        if (ram_we && i_mem_mask[gi]) begin
          lane_mem[ram_idx] <= i_mem_data[8*gi +: 8];
        end
        lane_rd_reg <= lane_mem[ram_idx];
      end

      assign ram_rd[8*gi +: 8] = lane_rd_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // GPIO register
  // ---------------------------------------------------------------------------
  logic [GPIO_W-1:0] gpio_reg;
  logic [GPIO_W-1:0] gpio_masked;
  logic [GPIO_W-1:0] gpio_next;

  generate
    for (gi = 0; gi < GPIO_W; gi++) begin : g_gpio
      assign gpio_masked[gi] = i_mem_mask[gi/8] ? i_mem_data[gi] : gpio_reg[gi];
    end
  endgenerate

  assign gpio_next = gpio_we ? gpio_masked : gpio_reg;

  // GPIO state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_reg <= '0;
    end else begin
      gpio_reg <= gpio_next;
    end
  end

  assign o_gpio = gpio_reg;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          ovf_reg, ovf_next;
  logic          fifo_empty;
  logic          fifo_full;
  logic          tx_pop;
  logic          push_ok;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
  assign tx_pop     = !fifo_empty && i_tx_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok    = push_req && (!fifo_full || tx_pop);

  // FIFO storage; contents are never reset, the pointers decide validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= i_mem_data[7:0];
    end
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;

    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + PW'(1);
    end
    if (tx_pop) begin
      rd_ptr_next = rd_ptr_reg + PW'(1);
    end
    case ({push_ok, tx_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase

    // A rejected push in the same cycle as a clear keeps the flag set.
    if (push_req && !push_ok) begin
      ovf_next = 1'b1;
    end else if (ovf_clr) begin
      ovf_next = 1'b0;
    end
  end

  // FIFO control registers; reset flushes the queue immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
    end
  end

  // Head byte is masked to zero while empty so stale entries never leak out.
  assign o_tx_valid = !fifo_empty;
  assign o_tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg];

  // ---------------------------------------------------------------------------
  // Optional cycle counter
  // ---------------------------------------------------------------------------
  logic [31:0] cycle_val;

`ifdef DATA_MEM_CYCLE_EN
  logic [31:0] cycle_reg;

  // Free-running counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_reg <= '0;
    end else begin
      cycle_reg <= cycle_reg + 32'd1;
    end
  end

  assign cycle_val = cycle_reg;
`else
  assign cycle_val = 32'd0;
`endif

  // ---------------------------------------------------------------------------
  // MMIO read mux and read-data register
  // ---------------------------------------------------------------------------
  logic [7:0]  count_ext;
  logic [31:0] stat_word;
  logic [31:0] mmio_rdata;
  logic        mmio_sel_reg;
  logic [31:0] mmio_rd_reg;

  assign count_ext = 8'(count_reg);
  assign stat_word = {21'd0, ovf_reg, fifo_full, fifo_empty, count_ext};

  // Select the MMIO word addressed by the low offset bits.
  always_comb begin
    mmio_rdata = 32'd0;
    case (mmio_off)
      OFF_GPIO: mmio_rdata = 32'(gpio_reg);
      OFF_STAT: mmio_rdata = stat_word;
      OFF_CYC:  mmio_rdata = cycle_val;
      default:  mmio_rdata = 32'd0;
    endcase
  end

  // Registered source select; reset selects the zeroed MMIO path so the
  // output reads 0 without needing to reset the RAM read registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmio_sel_reg <= 1'b1;
      mmio_rd_reg  <= '0;
    end else begin
      mmio_sel_reg <= mmio_hit;
      mmio_rd_reg  <= mmio_hit ? mmio_rdata : 32'd0;
    end
  end

  assign o_mem_data = mmio_sel_reg ? mmio_rd_reg : ram_rd;

endmodule
